// File: rtl/guardrail_pkg.sv
// Shared types and helpers for the IR guardrail monitor.
package guardrail_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StArmed  = 2'd1,
      StReport = 2'd2
   } guard_state_t;

   localparam int unsigned CH_LFT  = 0;
   localparam int unsigned CH_RGHT = 1;
   localparam int unsigned CH_CNTR = 2;

   function automatic int unsigned idx_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ir_debounce.sv
// One IR channel: 2-flop synchroniser on the inverted raw input plus a debounce counter.
module ir_debounce #(
   parameter int unsigned DEB_CYC = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_ir_n,
   output logic o_db
);

   localparam int unsigned CW = (DEB_CYC <= 2) ? 1 : $clog2(DEB_CYC);

   logic [1:0]    r_sync;
   logic [CW-1:0] r_cnt;
   logic          r_db;
   logic          w_s;

   assign w_s  = r_sync[1];
   assign o_db = r_db;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync <= 2'b00;
         r_cnt  <= '0;
         r_db   <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], ~i_ir_n};
         if (w_s == r_db) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(DEB_CYC - 1)) begin
            r_db  <= w_s;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ir_guardrail_monitor.sv
// N-channel IR guardrail monitor: debounce, per-window edge counting and violation latch.
// Optional watchdog enabled by defining GUARDRAIL_TIMEOUT_EN.
module ir_guardrail_monitor
   import guardrail_pkg::*;
#(
   parameter int unsigned NUM_CH  = 3,
   parameter int unsigned DEB_CYC = 4,
   parameter int unsigned CNT_W   = 4,
   parameter int unsigned TMO_CYC = 1000000
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [NUM_CH-1:0]         i_ir_n,
   input  logic                      i_arm,
   input  logic                      i_disarm,
   input  logic [NUM_CH-1:0]         i_allow_mask,
   output logic [NUM_CH-1:0]         o_ir_db,
   output logic                      o_busy,
   output logic                      o_done,
   output logic                      o_viol,
   output logic [idx_w(NUM_CH)-1:0]  o_first_ch,
   output logic [NUM_CH*CNT_W-1:0]   o_evt_cnt,
   output logic                      o_timeout
);

   localparam int unsigned IDX_W = idx_w(NUM_CH);

   guard_state_t r_state, w_state_d;

   logic [NUM_CH-1:0] w_db;
   logic [NUM_CH-1:0] r_db_q;
   logic [NUM_CH-1:0] w_rise;
   logic [NUM_CH-1:0] w_bad;
   logic [NUM_CH-1:0] r_mask;
   logic [CNT_W-1:0]  r_cnt [NUM_CH];
   logic              r_viol;
   logic [IDX_W-1:0]  r_first;
   logic [IDX_W-1:0]  w_low;
   logic              w_expire;
   logic              w_arm_ok;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      ir_debounce #(
         .DEB_CYC (DEB_CYC)
      ) u_deb (
         .i_clk  (i_clk),
         .i_rst  (i_rst),
         .i_ir_n (i_ir_n[g]),
         .o_db   (w_db[g])
      );
      assign o_evt_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
   end

   assign w_rise   = w_db & ~r_db_q;
   assign w_bad    = w_rise & ~r_mask;
   assign w_arm_ok = (r_state == StIdle) && i_arm;

   always_comb begin
      w_low = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (w_bad[i]) w_low = IDX_W'(i);
      end
   end

`ifdef GUARDRAIL_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TMO_CYC + 1);

   logic [WD_W-1:0] r_wd;
   logic            r_timeout;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wd <= '0;
      end else if (w_arm_ok) begin
         r_wd <= '0;
      end else if (r_state == StArmed) begin
         r_wd <= r_wd + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_timeout <= 1'b0;
      end else if (w_arm_ok) begin
         r_timeout <= 1'b0;
      end else if (w_expire && !i_disarm) begin
         r_timeout <= 1'b1;
      end
   end

   assign w_expire  = (r_state == StArmed) && (r_wd == WD_W'(TMO_CYC));
   assign o_timeout = r_timeout;
`else
   assign w_expire  = 1'b0;
   assign o_timeout = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= StIdle;
      else       r_state <= w_state_d;
   end

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:   if (i_arm) w_state_d = StArmed;
         StArmed:  if (i_disarm || w_expire) w_state_d = StReport;
         StReport: w_state_d = StIdle;
         default:  w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_db_q  <= '0;
         r_mask  <= '0;
         r_viol  <= 1'b0;
         r_first <= '0;
         for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
      end else begin
         r_db_q <= w_db;
         if (w_arm_ok) begin
            r_mask  <= i_allow_mask;
            r_viol  <= 1'b0;
            r_first <= '0;
            for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
         end else if (r_state == StArmed) begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (w_rise[i] && (r_cnt[i] != {CNT_W{1'b1}})) r_cnt[i] <= r_cnt[i] + 1'b1;
            end
            // Only the first violating cycle records a channel index.
            if (!r_viol && (|w_bad)) begin
               r_viol  <= 1'b1;
               r_first <= w_low;
            end
         end
      end
   end

   assign o_ir_db    = w_db;
   assign o_busy     = (r_state == StArmed);
   assign o_done     = (r_state == StReport);
   assign o_viol     = r_viol;
   assign o_first_ch = r_first;

endmodule

// File: tb/tb_ir_guardrail_monitor.sv
// Directed self-checking bench for ir_guardrail_monitor (NUM_CH=3, DEB_CYC=4, CNT_W=4, TMO_CYC=100).
module tb_ir_guardrail_monitor;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [2:0]  ir_n = 3'b111;
   logic        arm = 1'b0;
   logic        disarm = 1'b0;
   logic [2:0]  allow_mask = 3'b000;
   logic [2:0]  ir_db;
   logic        busy;
   logic        done;
   logic        viol;
   logic [1:0]  first_ch;
   logic [11:0] evt_cnt;
   logic        timeout;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ir_guardrail_monitor #(
      .NUM_CH  (3),
      .DEB_CYC (4),
      .CNT_W   (4),
      .TMO_CYC (100)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_ir_n       (ir_n),
      .i_arm        (arm),
      .i_disarm     (disarm),
      .i_allow_mask (allow_mask),
      .o_ir_db      (ir_db),
      .o_busy       (busy),
      .o_done       (done),
      .o_viol       (viol),
      .o_first_ch   (first_ch),
      .o_evt_cnt    (evt_cnt),
      .o_timeout    (timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_arm(input logic [2:0] mask);
      allow_mask = mask;
      arm = 1'b1;
      tick(1);
      arm = 1'b0;
   endtask

   task automatic do_disarm();
      disarm = 1'b1;
      tick(1);
      disarm = 1'b0;
   endtask

   task automatic pulse(input logic [2:0] chans);
      ir_n = ir_n & ~chans;
      tick(8);
      ir_n = ir_n | chans;
      tick(8);
   endtask

   logic seen;
   int   lat;

   initial begin
      // Reset
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      chk("rst_db", {29'd0, ir_db}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_viol", {31'd0, viol}, 32'd0);
      chk("rst_first", {30'd0, first_ch}, 32'd0);
      chk("rst_cnt", {20'd0, evt_cnt}, 32'd0);
      chk("rst_tmo", {31'd0, timeout}, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (ir_db != 3'b000) seen = 1'b1;
      end
      chk("idle_db", {31'd0, seen}, 32'd0);

      // Glitch rejection and debounce latency on channel 1
      do_arm(3'b010);
      chk("arm_busy", {31'd0, busy}, 32'd1);
      ir_n[1] = 1'b0;
      tick(3);
      ir_n[1] = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         if (ir_db[1]) seen = 1'b1;
      end
      chk("glitch_db", {31'd0, seen}, 32'd0);
      chk("glitch_cnt1", {28'd0, evt_cnt[7:4]}, 32'd0);
      ir_n[1] = 1'b0;
      lat = 0;
      for (int k = 1; k <= 12; k++) begin
         tick(1);
         if (ir_db[1] && lat == 0) lat = k;
      end
      chk("deb_latency", lat, 32'd6);
      ir_n[1] = 1'b1;
      tick(10);
      chk("deb_cnt1", {28'd0, evt_cnt[7:4]}, 32'd1);
      chk("deb_viol", {31'd0, viol}, 32'd0);
      do_disarm();
      tick(1);

      // Allowed traffic on channel 2
      do_arm(3'b100);
      for (int p = 0; p < 5; p++) pulse(3'b100);
      chk("ok_cnt2", {28'd0, evt_cnt[11:8]}, 32'd5);
      arm = 1'b1;
      tick(1);
      arm = 1'b0;
      chk("rearm_ignored_cnt2", {28'd0, evt_cnt[11:8]}, 32'd5);
      chk("rearm_ignored_busy", {31'd0, busy}, 32'd1);
      do_disarm();
      chk("ok_done", {31'd0, done}, 32'd1);
      chk("ok_busy_fall", {31'd0, busy}, 32'd0);
      chk("ok_cnt0", {28'd0, evt_cnt[3:0]}, 32'd0);
      chk("ok_cnt1", {28'd0, evt_cnt[7:4]}, 32'd0);
      chk("ok_viol", {31'd0, viol}, 32'd0);
      tick(1);
      chk("ok_done_once", {31'd0, done}, 32'd0);
      chk("ok_hold_cnt2", {28'd0, evt_cnt[11:8]}, 32'd5);

      // Simultaneous violation on channels 0 and 1
      do_arm(3'b100);
      pulse(3'b011);
      pulse(3'b010);
      chk("sim_viol", {31'd0, viol}, 32'd1);
      chk("sim_first", {30'd0, first_ch}, 32'd0);
      chk("sim_cnt0", {28'd0, evt_cnt[3:0]}, 32'd1);
      chk("sim_cnt1", {28'd0, evt_cnt[7:4]}, 32'd2);
      do_disarm();
      tick(1);

      // Saturation with violations on channel 2, then re-arm clears
      do_arm(3'b000);
      for (int p = 0; p < 20; p++) pulse(3'b100);
      chk("sat_cnt2", {28'd0, evt_cnt[11:8]}, 32'd15);
      chk("sat_viol", {31'd0, viol}, 32'd1);
      chk("sat_first", {30'd0, first_ch}, 32'd2);
      do_disarm();
      tick(1);
      chk("sat_hold_cnt2", {28'd0, evt_cnt[11:8]}, 32'd15);
      do_arm(3'b100);
      chk("rearm_cnt", {20'd0, evt_cnt}, 32'd0);
      chk("rearm_viol", {31'd0, viol}, 32'd0);
      chk("rearm_first", {30'd0, first_ch}, 32'd0);
      arm = 1'b1;
      disarm = 1'b1;
      tick(1);
      arm = 1'b0;
      disarm = 1'b0;
      chk("armdis_done", {31'd0, done}, 32'd1);
      chk("armdis_busy", {31'd0, busy}, 32'd0);
      tick(1);
      chk("armdis_idle_busy", {31'd0, busy}, 32'd0);

      // Channel already high at arm is not counted
      ir_n[0] = 1'b0;
      tick(10);
      do_arm(3'b001);
      tick(10);
      chk("prehigh_cnt0", {28'd0, evt_cnt[3:0]}, 32'd0);
      ir_n[0] = 1'b1;
      tick(10);
      do_disarm();
      tick(1);

      // Reset mid-window aborts without done
      do_arm(3'b111);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("rstwin_busy", {31'd0, busy}, 32'd0);
      chk("rstwin_done", {31'd0, done}, 32'd0);
      tick(1);
      chk("rstwin_done2", {31'd0, done}, 32'd0);

      // Watchdog
      do_arm(3'b111);
`ifdef GUARDRAIL_TIMEOUT_EN
      lat = 0;
      for (int k = 1; k <= 200; k++) begin
         tick(1);
         if (done && lat == 0) begin
            lat = k;
            chk("tmo_flag", {31'd0, timeout}, 32'd1);
         end
      end
      chk("tmo_latency", lat, 32'd101);
      chk("tmo_busy", {31'd0, busy}, 32'd0);
`else
      tick(150);
      chk("notmo_busy", {31'd0, busy}, 32'd1);
      chk("notmo_flag", {31'd0, timeout}, 32'd0);
      do_disarm();
      chk("notmo_done", {31'd0, done}, 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ir_guardrail_monitor.md
Name: ir_guardrail_monitor

Overview:
Parametrised N-channel monitor for the Knight's IR guardrail/line sensors (lftIR_n, cntrIR_n, rghtIR_n and future extras).
- Synchronises and debounces each active-low IR input.
- During an armed move window, counts assertions per channel.
- Flags any assertion on a channel not allowed for that move, and latches the first offending channel.
- Sits beside the motion controller: the command layer arms it at move start and disarms it at move end. It turns the guardrail check into an on-chip status that the command layer can report back over UART.

Parameters:
NUM_CH, 3, number of IR channels (index 0 = left, 1 = right, 2 = centre by convention)
DEB_CYC, 4, consecutive stable synchronised cycles needed to change a debounced level (>=1)
CNT_W, 4, width of each per-channel saturating event counter
TMO_CYC, 1000000, armed-window watchdog length in clocks (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
ir_n  in  NUM_CH  raw active-low IR inputs, asynchronous to clk
arm  in  1  one-cycle pulse: open a monitoring window
disarm  in  1  one-cycle pulse: close the window
allow_mask  in  NUM_CH  channels permitted to assert during the window; sampled on arm
ir_db  out  NUM_CH  debounced active-high IR levels
busy  out  1  high while in ARMED
done  out  1  one-cycle pulse when a window closes
viol  out  1  sticky: a disallowed channel asserted in the current/last window
first_ch  out  $clog2(NUM_CH) (min 1)  index of first violating channel; valid when viol=1
evt_cnt  out  NUM_CH*CNT_W  flattened per-channel rising-edge counts; channel i at [i*CNT_W +: CNT_W]
timeout  out  1  sticky: window closed by watchdog; tied 0 without the optional feature

Behaviour:
- Reset (synchronous, rst=1 at a posedge):
  - ir_db, busy, done, viol, first_ch, evt_cnt and timeout all go to 0.
  - The synchronisers and debounce counters clear; the FSM goes to IDLE.
  - A reset mid-window aborts the window with no done pulse.
- Input path per channel:
  - A 2-flop synchroniser on ~ir_n gives s.
  - A debounce counter clears whenever s == ir_db. Otherwise it increments.
  - When s != ir_db and the counter reaches DEB_CYC-1, ir_db <= s on that edge and the counter clears.
  - A clean raw change therefore appears on ir_db DEB_CYC+2 edges later. Pulses shorter than DEB_CYC synchronised cycles are rejected.
- Edge detection: rise[i] = ir_db[i] & ~ir_db_q[i]. Debouncing and edge detection run in every state.
- FSM states: IDLE, ARMED, REPORT.
  - IDLE --arm--> ARMED. On that edge: evt_cnt, viol, first_ch and timeout clear, and allow_mask is latched. disarm in IDLE is ignored.
  - ARMED:
    - For each channel with rise[i], evt_cnt[i] increments, saturating at 2^CNT_W-1.
    - If rise[i] occurs with latched mask bit i = 0:
      - If viol is 0, set viol and set first_ch to the lowest such index in that cycle.
      - Later violations do not change first_ch.
    - arm in ARMED is ignored.
    - disarm --> REPORT. If arm and disarm arrive together, disarm wins.
    - A rise in the same cycle as disarm is still counted.
  - REPORT: done=1 for exactly this one cycle, then IDLE unconditionally. Edges in REPORT/IDLE are not counted.
- busy=1 exactly while in ARMED.
- Results (evt_cnt, viol, first_ch, timeout) hold until the next accepted arm.
- A channel already high at arm is not counted until it falls and rises again.

Optional Feature:
Macro GUARDRAIL_TIMEOUT_EN.
- Defined:
  - A watchdog of width $clog2(TMO_CYC+1) clears on arm and increments in ARMED.
  - When it reaches TMO_CYC with no disarm, the FSM sets timeout=1 and moves to REPORT (done pulses).
  - If disarm arrives on the expiry cycle, disarm wins and timeout stays 0.
- Not defined: no watchdog logic is built; timeout is constant 0.

Decomposition:
- Package guardrail_pkg holds:
  - the FSM enum (IDLE, ARMED, REPORT);
  - the index-width function (max(1, $clog2(n)));
  - the default channel-index constants (CH_LFT=0, CH_RGHT=1, CH_CNTR=2).
- Sub-module ir_debounce (synchroniser + debounce counter, parameter DEB_CYC) is instantiated NUM_CH times in a generate loop.
- FSM, counters and violation logic stay in the top module.

Test Plan:
1. Reset behaviour: assert rst for 2 cycles with ir_n=3'b111 -> all outputs 0; ir_db stays 3'b000 for 10 further idle cycles.
2. Glitch rejection (DEB_CYC=4): ir_n[1]=0 for 3 cycles while armed -> ir_db[1] never rises; evt_cnt[1]=0. Holding it 0 for 10 cycles -> ir_db[1] rises exactly 6 edges after the raw change.
3. Allowed traffic: arm with allow_mask=3'b100, then 5 clean pulses on channel 2, then disarm -> evt_cnt[2]=5, others 0, viol=0, done high 1 cycle, busy falls with done.
4. Simultaneous violation: armed with mask 3'b100, channels 0 and 1 rise together, then channel 1 again -> viol=1, first_ch=0, evt_cnt[0]=1, evt_cnt[1]=2.
5. Saturation and re-arm: 20 pulses on channel 2 -> evt_cnt[2]=15. Disarm then arm -> counts and viol read 0 the cycle after arm. arm+disarm in the same ARMED cycle -> REPORT, not re-arm.
6. Timeout (macro defined, TMO_CYC=100): arm with no disarm -> timeout=1 and done pulse 101 cycles after arm; with the macro undefined, busy stays 1 indefinitely and timeout=0.
